// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key_len encodings, Rcon, Nk/Nr/T lookups, FSM states.
// AES_KEYSCHED_LONG_KEY_EN enables AES-192/256 support and the 60-word store.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;

`ifdef AES_KEYSCHED_LONG_KEY_EN
    localparam int unsigned STORE_WORDS = 60;
`else
    localparam int unsigned STORE_WORDS = 44;
`endif
    localparam logic [5:0] STORE_LAST = 6'(STORE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } ks_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] c);
        case (c)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Without long-key support every lookup folds to the AES-128 constants.
    function automatic logic key_len_legal(input logic [1:0] kl);
`ifdef AES_KEYSCHED_LONG_KEY_EN
        key_len_legal = (kl != 2'b11);
`else
        key_len_legal = (kl == KEY_LEN_128);
`endif
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
`ifdef AES_KEYSCHED_LONG_KEY_EN
        case (kl)
            KEY_LEN_192: nk_of = 4'd6;
            KEY_LEN_256: nk_of = 4'd8;
            default:     nk_of = 4'd4;
        endcase
`else
        nk_of = (kl == 2'b11) ? 4'd4 : 4'd4;
`endif
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
`ifdef AES_KEYSCHED_LONG_KEY_EN
        case (kl)
            KEY_LEN_192: nr_of = 4'd12;
            KEY_LEN_256: nr_of = 4'd14;
            default:     nr_of = 4'd10;
        endcase
`else
        nr_of = (kl == 2'b11) ? 4'd10 : 4'd10;
`endif
    endfunction

    function automatic logic [5:0] total_of(input logic [1:0] kl);
`ifdef AES_KEYSCHED_LONG_KEY_EN
        case (kl)
            KEY_LEN_192: total_of = 6'd52;
            KEY_LEN_256: total_of = 6'd60;
            default:     total_of = 6'd44;
        endcase
`else
        total_of = (kl == 2'b11) ? 6'd44 : 6'd44;
`endif
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte S-box: GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Square-and-multiply chain to x^254; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    logic [7:0] inv_s;

    // Inverse then affine map with constant 0x63.
    always_comb begin
        inv_s   = gf_inv(byte_val);
        sub_val = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
                ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_schedule.sv
// One-word-per-cycle AES key expander with random-access round-key read port.
// Define AES_KEYSCHED_LONG_KEY_EN to add AES-192/256; default build is AES-128 only.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    output logic         key_err,
    input  logic [3:0]   rk_round,
    output logic [127:0] rk_out
);

    ks_state_t      state_r;
    logic [255:0]   key_r;
    logic [1:0]     key_len_r;
    logic [5:0]     idx_r;
    logic [2:0]     j_r;
    logic [3:0]     c_r;
    logic [31:0]    prev_r;
    logic           busy_r;
    logic           valid_r;
    logic           err_r;
    logic [31:0]    store_r [STORE_WORDS];

    logic [3:0]     nk_s;
    logic [3:0]     nr_s;
    logic [5:0]     total_s;
    logic [31:0]    key_word_s;
    logic [5:0]     back_idx_s;
    logic [31:0]    back_s;
    logic [31:0]    sbox_in_s;
    logic [31:0]    sub_s;
    logic [31:0]    temp_s;
    logic [31:0]    new_word_s;
    logic           wr_en_s;
    logic [31:0]    wr_word_s;
    logic [5:0]     rd_base_s;
    logic [127:0]   rk_comb_s;

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_subword
            aes_sbox u_sbox (
                .byte_val (sbox_in_s[8*b +: 8]),
                .sub_val  (sub_s[8*b +: 8])
            );
        end
    endgenerate

    // Next-word datapath; prev_r always holds w[i-1].
    always_comb begin
        nk_s       = nk_of(key_len_r);
        nr_s       = nr_of(key_len_r);
        total_s    = total_of(key_len_r);
        key_word_s = key_r[(8'd255 - {idx_r[2:0], 5'd0}) -: 32];
        back_idx_s = idx_r - {2'b00, nk_s};
        if (back_idx_s <= STORE_LAST) begin
            back_s = store_r[back_idx_s];
        end else begin
            back_s = 32'h0;
        end
        if (j_r == 3'd0) begin
            sbox_in_s = {prev_r[23:0], prev_r[31:24]};
        end else begin
            sbox_in_s = prev_r;
        end
        if (j_r == 3'd0) begin
            temp_s = sub_s ^ {rcon(c_r), 24'h000000};
`ifdef AES_KEYSCHED_LONG_KEY_EN
        end else if ((nk_s == 4'd8) && (j_r == 3'd4)) begin
            temp_s = sub_s;
`endif
        end else begin
            temp_s = prev_r;
        end
        new_word_s = back_s ^ temp_s;
        wr_en_s    = (state_r == ST_LOAD) || (state_r == ST_EXPAND);
        if (state_r == ST_LOAD) begin
            wr_word_s = key_word_s;
        end else begin
            wr_word_s = new_word_s;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            key_r     <= 256'h0;
            key_len_r <= 2'b00;
            idx_r     <= 6'd0;
            j_r       <= 3'd0;
            c_r       <= 4'd1;
            prev_r    <= 32'h0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (key_len_legal(key_len)) begin
                            state_r   <= ST_LOAD;
                            key_r     <= key_in;
                            key_len_r <= key_len;
                            idx_r     <= 6'd0;
                            j_r       <= 3'd0;
                            c_r       <= 4'd1;
                            valid_r   <= 1'b0;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    busy_r <= 1'b1;
                    prev_r <= key_word_s;
                    idx_r  <= idx_r + 6'd1;
                    if (idx_r == ({2'b00, nk_s} - 6'd1)) begin
                        state_r <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    busy_r <= 1'b1;
                    prev_r <= new_word_s;
                    idx_r  <= idx_r + 6'd1;
                    if ({1'b0, j_r} == (nk_s - 4'd1)) begin
                        j_r <= 3'd0;
                    end else begin
                        j_r <= j_r + 3'd1;
                    end
                    if (j_r == 3'd0) begin
                        c_r <= c_r + 4'd1;
                    end
                    if (idx_r == (total_s - 6'd1)) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    valid_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Round-key store, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STORE_WORDS; k++) begin
                store_r[k] <= 32'h0;
            end
        end else if (wr_en_s) begin
            store_r[idx_r] <= wr_word_s;
        end
    end

    // Read mux; rounds beyond Nr of the latched key length read as zero.
    always_comb begin
        rd_base_s = {rk_round, 2'b00};
        if (rk_round > nr_s) begin
            rk_comb_s = 128'h0;
        end else begin
            rk_comb_s = {store_r[rd_base_s], store_r[rd_base_s + 6'd1],
                         store_r[rd_base_s + 6'd2], store_r[rd_base_s + 6'd3]};
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [127:0] rk_out_r;
            // One-cycle registered read.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rk_out_r <= 128'h0;
                end else begin
                    rk_out_r <= rk_comb_s;
                end
            end
            assign rk_out = rk_out_r;
        end else begin : g_out_comb
            assign rk_out = rk_comb_s;
        end
    endgenerate

    assign busy       = busy_r;
    assign keys_valid = valid_r;
    assign key_err    = err_r;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 vectors plus random keys against a reference model.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic         key_err;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  sb [256];
    logic [7:0]  rc_tb [16];
    logic [31:0] mw [60];

    aes_key_schedule #(.OUT_REG(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_len    (key_len),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .key_err    (key_err),
        .rk_round   (rk_round),
        .rk_out     (rk_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, cur;
        acc = 8'h00;
        cur = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ cur;
            cur = xtime(cur);
        end
        return acc;
    endfunction

    // S-box by brute-force inverse search and bitwise affine formula.
    task automatic build_tables;
        logic [7:0] inv, a, o, cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            a = inv;
            for (int i = 0; i < 8; i++) begin
                o[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8] ^ cst[i];
            end
            sb[x] = o;
        end
        rc_tb[0] = 8'h00;
        rc_tb[1] = 8'h01;
        for (int i = 2; i < 16; i++) rc_tb[i] = xtime(rc_tb[i - 1]);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic build_model(input logic [1:0] kl, input logic [255:0] k);
        int nk, nr;
        logic [31:0] t;
        nk = 4 + 2 * int'(kl);
        nr = nk + 6;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                mw[i] = k[255 - 32 * i -: 32];
            end else begin
                t = mw[i - 1];
                if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc_tb[i / nk], 24'h0};
                else if (nk == 8 && i % nk == 4) t = subw(t);
                mw[i] = mw[i - nk] ^ t;
            end
        end
    endtask

    task automatic read_round(input int r, output logic [127:0] val);
        rk_round = 4'(r);
        tick;
        val = rk_out;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (cycles < 200 && keys_valid !== 1'b1) begin
            tick;
            cycles++;
        end
    endtask

    task automatic run_key(input logic [1:0] kl, input logic [255:0] k, output int cycles);
        key_len = kl;
        key_in  = k;
        start   = 1'b1;
        tick;
        start = 1'b0;
        wait_valid(cycles);
    endtask

    task automatic check_all(input string tag, input logic [1:0] kl, input logic [255:0] k);
        int nr;
        logic [127:0] v;
        nr = 10 + 2 * int'(kl);
        build_model(kl, k);
        for (int r = 0; r <= nr; r++) begin
            read_round(r, v);
            check_val($sformatf("%s_rk%0d", tag, r), v, {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
        end
        read_round(nr + 1, v);
        check_val($sformatf("%s_beyond_nr", tag), v, 128'h0);
    endtask

    initial begin
        int cyc;
        logic [127:0] v;
        logic [255:0] k;
        logic [1:0] kl;
        build_tables();
        reset = 1'b1; start = 1'b0; key_len = 2'b00; key_in = 256'h0; rk_round = 4'd0;
        tick; tick;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_valid", keys_valid, 1'b0);
        check_val("rst_err", key_err, 1'b0);
        check_val("rst_rk", rk_out, 128'h0);
        reset = 1'b0;
        tick;

        // Illegal key length: one-cycle error pulse, no activity.
        key_len = 2'b11; start = 1'b1; tick; start = 1'b0;
        check_val("ill_err", key_err, 1'b1);
        check_val("ill_busy", busy, 1'b0);
        check_val("ill_valid", keys_valid, 1'b0);
        tick;
        check_val("ill_err_pulse", key_err, 1'b0);
        check_val("ill_valid2", keys_valid, 1'b0);

        // AES-128 FIPS-197 vector.
        run_key(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, cyc);
        check_val("a128_cycles", 128'(cyc), 128'd45);
        check_val("a128_busy_done", busy, 1'b0);
        read_round(10, v);
        check_val("a128_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_round(1, v);
        check_val("a128_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
        check_all("a128", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});

`ifdef AES_KEYSCHED_LONG_KEY_EN
        run_key(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, cyc);
        check_val("a192_cycles", 128'(cyc), 128'd53);
        read_round(12, v);
        check_val("a192_rk12", v, 128'he98ba06f448c773c8ecc720401002202);
        check_all("a192", 2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        run_key(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, cyc);
        check_val("a256_cycles", 128'(cyc), 128'd61);
        read_round(14, v);
        check_val("a256_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);
`else
        for (int e = 1; e < 3; e++) begin
            key_len = 2'(e); start = 1'b1; tick; start = 1'b0;
            check_val($sformatf("short_err_%0d", e), key_err, 1'b1);
            check_val($sformatf("short_busy_%0d", e), busy, 1'b0);
            tick;
        end
`endif

        // Back-to-back restart while valid; a start during busy is ignored.
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_len = 2'b00; key_in = k; start = 1'b1; tick; start = 1'b0;
        check_val("restart_valid_drop", keys_valid, 1'b0);
        tick;
        check_val("restart_busy", busy, 1'b1);
        repeat (8) tick;
        key_in = ~k; start = 1'b1; tick; start = 1'b0;
        wait_valid(cyc);
        check_val("busy_start_cycles", 128'(cyc), 128'd35);
        check_all("busy_start", 2'b00, k);

        // Reset mid-expansion aborts everything.
`ifdef AES_KEYSCHED_LONG_KEY_EN
        key_len = 2'b10;
`else
        key_len = 2'b00;
`endif
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start = 1'b1; tick; start = 1'b0;
        repeat (20) tick;
        reset = 1'b1;
        #1;
        check_val("midrst_busy", busy, 1'b0);
        check_val("midrst_valid", keys_valid, 1'b0);
        check_val("midrst_err", key_err, 1'b0);
        check_val("midrst_rk", rk_out, 128'h0);
        tick;
        reset = 1'b0;
        read_round(0, v);
        check_val("midrst_store", v, 128'h0);
        k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        run_key(2'b00, k, cyc);
        check_val("postrst_cycles", 128'(cyc), 128'd45);
        check_all("postrst", 2'b00, k);

        // Random keys over every supported length.
        for (int n = 0; n < 6; n++) begin
`ifdef AES_KEYSCHED_LONG_KEY_EN
            kl = 2'($urandom_range(0, 2));
`else
            kl = 2'b00;
`endif
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_key(kl, k, cyc);
            check_val($sformatf("rnd%0d_cycles", n), 128'(cyc), 128'(4 * (11 + 2 * int'(kl)) + 1));
            check_all($sformatf("rnd%0d", n), kl, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
